// File: rtl/bootstrap_loader_pkg.sv
// Types and constants shared by the bootstrap loader and its checksum helper.
package common;

  localparam int BOOTSTRAP_ADDR_W = 12;
  localparam int BOOT_DATA_W      = 8;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

endpackage

// File: rtl/bootstrap_loader_checksum.sv
// Modulo-256 running sum of accepted payload bytes.
// Only compiled when BOOTSTRAP_CHECKSUM_EN is defined.
`ifdef BOOTSTRAP_CHECKSUM_EN
module bootstrap_checksum
  import common::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   add_i,
  input  logic [BOOT_DATA_W-1:0] data_i,
  output logic [BOOT_DATA_W-1:0] sum_o
);

  logic [BOOT_DATA_W-1:0] sum_q;
  logic [BOOT_DATA_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/bootstrap_loader.sv
// Streams boot bytes into microcode SRAM using a SETUP/STROBE/HOLD cycle per byte.
// Define BOOTSTRAP_CHECKSUM_EN to require a trailer byte that zeroes the payload sum.
module bootstrap_loader
  import common::*;
#(
  parameter int LENGTH = 4096
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [BOOT_DATA_W-1:0]      IN_DATA,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [BOOTSTRAP_ADDR_W-1:0] BOOTSTRAP_ADDR,
  output logic [BOOT_DATA_W-1:0]      BOOTSTRAP_DATA,
  output logic                        BOOTSTRAP_N_WE,
  output logic                        N_BOOTED,
  output logic                        ERROR
);

  localparam logic [BOOTSTRAP_ADDR_W-1:0] LAST_ADDR = BOOTSTRAP_ADDR_W'(LENGTH - 1);
  localparam logic [BOOTSTRAP_ADDR_W-1:0] ADDR_ONE  = BOOTSTRAP_ADDR_W'(1);

  boot_state_e                 state_q;
  boot_state_e                 state_d;
  logic [BOOTSTRAP_ADDR_W-1:0] addr_q;
  logic [BOOTSTRAP_ADDR_W-1:0] addr_d;
  logic [BOOT_DATA_W-1:0]      data_q;
  logic [BOOT_DATA_W-1:0]      data_d;
  logic                        n_we_q;
  logic                        n_we_d;
  logic                        n_booted_q;
  logic                        n_booted_d;
  logic                        ready;

`ifdef BOOTSTRAP_CHECKSUM_EN
  logic                        sum_add;
  logic [BOOT_DATA_W-1:0]      sum;
  logic                        error_q;
  logic                        error_d;

  bootstrap_checksum u_checksum (
    .clk_i  (CLK),
    .rst_i  (RST),
    .add_i  (sum_add),
    .data_i (IN_DATA),
    .sum_o  (sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready   = 1'b0;
`ifdef BOOTSTRAP_CHECKSUM_EN
    sum_add = 1'b0;
`endif
    case (state_q)
      ST_WAIT: begin
        ready = 1'b1;
        if (IN_VALID) begin
          data_d  = IN_DATA;
          state_d = ST_SETUP;
`ifdef BOOTSTRAP_CHECKSUM_EN
          sum_add = 1'b1;
`endif
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // The address saturates at the last byte so the final write is never followed by a wrap.
        if (addr_q != LAST_ADDR) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_WAIT;
        end else begin
`ifdef BOOTSTRAP_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef BOOTSTRAP_CHECKSUM_EN
      ST_CHECK: begin
        ready = 1'b1;
        if (IN_VALID) begin
          state_d = ((sum + IN_DATA) == '0) ? ST_DONE : ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
`endif
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Strobe and boot flags are registered from the next state so they leave the flops glitch-free.
  assign n_we_d     = (state_d != ST_STROBE);
  assign n_booted_d = (state_d != ST_DONE);
`ifdef BOOTSTRAP_CHECKSUM_EN
  assign error_d    = (state_d == ST_ERROR);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_WAIT;
      addr_q     <= '0;
      data_q     <= '0;
      n_we_q     <= 1'b1;
      n_booted_q <= 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      n_we_q     <= n_we_d;
      n_booted_q <= n_booted_d;
`ifdef BOOTSTRAP_CHECKSUM_EN
      error_q    <= error_d;
`endif
    end
  end

  assign IN_READY       = ready & ~RST;
  assign BOOTSTRAP_ADDR = addr_q;
  assign BOOTSTRAP_DATA = data_q;
  assign BOOTSTRAP_N_WE = n_we_q;
  assign N_BOOTED       = n_booted_q;
`ifdef BOOTSTRAP_CHECKSUM_EN
  assign ERROR          = error_q;
`else
  assign ERROR          = 1'b0;
`endif

endmodule

// File: tb/tb_bootstrap_loader.sv
// Randomized and directed bench for bootstrap_loader: a 4-byte instance and a full 4096-byte instance.
module tb_bootstrap_loader;

  localparam int LEN_A = 4;
  localparam int LEN_B = 4096;
`ifdef BOOTSTRAP_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ready_a, nwe_a, nboot_a, err_a;
  logic [7:0]  data_a, wdata_a;
  logic [11:0] addr_a;
  logic        rst_b, valid_b, ready_b, nwe_b, nboot_b, err_b;
  logic [7:0]  data_b, wdata_b;
  logic [11:0] addr_b;

  bootstrap_loader #(.LENGTH(LEN_A)) u_dut (
    .CLK(clk), .RST(rst_a), .IN_DATA(data_a), .IN_VALID(valid_a), .IN_READY(ready_a),
    .BOOTSTRAP_ADDR(addr_a), .BOOTSTRAP_DATA(wdata_a), .BOOTSTRAP_N_WE(nwe_a),
    .N_BOOTED(nboot_a), .ERROR(err_a)
  );

  bootstrap_loader #(.LENGTH(LEN_B)) u_dut_full (
    .CLK(clk), .RST(rst_b), .IN_DATA(data_b), .IN_VALID(valid_b), .IN_READY(ready_b),
    .BOOTSTRAP_ADDR(addr_b), .BOOTSTRAP_DATA(wdata_b), .BOOTSTRAP_N_WE(nwe_b),
    .N_BOOTED(nboot_b), .ERROR(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        wr_a[$];
  wr_t        wr_b[$];
  int         hs_a[$];
  logic [7:0] pl[$];
  logic [7:0] trailer;
  int         done_cyc_a  = -1;
  logic       prev_nwe_a  = 1'b1;
  logic       prev_nwe_b  = 1'b1;
  logic       prev_boot_a = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: records every strobe cycle and flags protocol violations.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (nwe_a === 1'b0) begin
      w.addr = int'(addr_a); w.data = int'(wdata_a); w.cyc = cyc;
      wr_a.push_back(w);
      if (prev_nwe_a === 1'b0 || nboot_a !== 1'b1) viol++;
    end
    if (nboot_a === 1'b0 && prev_boot_a === 1'b1) done_cyc_a = cyc;
    prev_nwe_a  = nwe_a;
    prev_boot_a = nboot_a;
    if (nwe_b === 1'b0) begin
      w.addr = int'(addr_b); w.data = int'(wdata_b); w.cyc = cyc;
      wr_b.push_back(w);
      if (prev_nwe_b === 1'b0 || nboot_b !== 1'b1) viol++;
    end
    prev_nwe_b = nwe_b;
  end

  function automatic logic [7:0] good_trailer();
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
    #1 check("rst_in_ready", ready_a, 1'b0);
    @(negedge clk);
    check("rst_addr", addr_a, 0);
    check("rst_data", wdata_a, 0);
    check("rst_n_we", nwe_a, 1);
    check("rst_n_booted", nboot_a, 1);
    check("rst_error", err_a, 0);
    rst_a = 1'b0;
    wr_a.delete(); hs_a.delete(); done_cyc_a = -1;
  endtask

  task automatic send_a(input logic [7:0] b, input int idle);
    repeat (idle) begin
      @(negedge clk);
      valid_a = 1'b0;
    end
    @(negedge clk);
    valid_a = 1'b1; data_a = b;
    for (int t = 0; t < 64; t++) begin
      #1;
      if (ready_a === 1'b1) begin
        @(posedge clk);
        #1;
        hs_a.push_back(cyc - 1);
        return;
      end
      @(negedge clk);
    end
    check("hs_timeout", 0, 1);
  endtask

  task automatic finish_load_a(input string tag, input int max_idle);
    int s = 0;
    int t = 0;
    int n;
    bit ok;
    foreach (pl[i]) s += int'(pl[i]);
    ok = !CKS || (((s + int'(trailer)) % 256) == 0);
`ifdef BOOTSTRAP_CHECKSUM_EN
    send_a(trailer, $urandom_range(0, max_idle));
`endif
    @(negedge clk);
    valid_a = 1'b0;
    while (nboot_a === 1'b1 && err_a !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end_timeout"}, t < 40, 1);
    n = wr_a.size();
    check({tag, "_nwrites"}, n, pl.size());
    for (int i = 0; i < n && i < pl.size() && i < hs_a.size(); i++) begin
      check({tag, "_addr"}, wr_a[i].addr, i);
      check({tag, "_data"}, wr_a[i].data, int'(pl[i]));
      check({tag, "_latency"}, wr_a[i].cyc - hs_a[i], 2);
    end
    check({tag, "_n_booted"}, nboot_a, !ok);
    check({tag, "_error"}, err_a, CKS && !ok);
    check({tag, "_in_ready"}, ready_a, 0);
    if (ok && hs_a.size() > 0)
      check({tag, "_done_latency"}, done_cyc_a - hs_a[hs_a.size()-1], CKS ? 1 : 4);
    $display("[TB] load %s: %0d bytes, sum %0h, trailer %0h, expect booted=%0d", tag, pl.size(), s % 256, trailer, ok);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int bad;
    int t;
    int sum_b;
    logic [7:0] exp_b[LEN_B];

    rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; trailer = 8'h00;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;

    // Back-to-back stream with IN_VALID held high.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    trailer = good_trailer();
    reset_a();
    foreach (pl[i]) send_a(pl[i], 0);
    finish_load_a("stream", 0);
    for (int i = 1; i < wr_a.size(); i++)
      check("stream_spacing", wr_a[i].cyc - wr_a[i-1].cyc, 4);

    // Source stalls after the first byte.
    reset_a();
    send_a(pl[0], 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      valid_a = 1'b0;
      if (j >= 3) begin
        #1;
        check("gap_in_ready", ready_a, 1);
        check("gap_n_we", nwe_a, 1);
        check("gap_addr", addr_a, 1);
      end
    end
    for (int i = 1; i < LEN_A; i++) send_a(pl[i], 0);
    finish_load_a("gap", 0);

    // Reset asserted during the strobe of the third byte.
    pl = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    reset_a();
    for (int i = 0; i < 3; i++) send_a(pl[i], 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_pre_n_we", nwe_a, 0);
    check("abort_pre_addr", addr_a, 2);
    rst_a = 1'b1; valid_a = 1'b0;
    @(posedge clk);
    #1;
    check("abort_n_we", nwe_a, 1);
    check("abort_addr", addr_a, 0);
    check("abort_n_booted", nboot_a, 1);
    @(negedge clk);
    rst_a = 1'b0;
    wr_a.delete(); hs_a.delete(); done_cyc_a = -1;
    pl = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    trailer = good_trailer();
    foreach (pl[i]) send_a(pl[i], $urandom_range(0, 2));
    finish_load_a("reload", 2);

    // Extra traffic after DONE must be ignored.
    n0 = wr_a.size();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      valid_a = 1'b1; data_a = 8'hFF;
      #1;
      check("post_in_ready", ready_a, 0);
      check("post_n_we", nwe_a, 1);
      check("post_n_booted", nboot_a, 0);
    end
    @(negedge clk);
    valid_a = 1'b0;
    check("post_nwrites", wr_a.size(), n0);

`ifdef BOOTSTRAP_CHECKSUM_EN
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    trailer = 8'hF6;
    reset_a();
    foreach (pl[i]) send_a(pl[i], 0);
    finish_load_a("cks_good", 0);
    trailer = 8'hF7;
    reset_a();
    foreach (pl[i]) send_a(pl[i], 0);
    finish_load_a("cks_bad", 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      valid_a = 1'b1; data_a = 8'h00;
      #1;
      check("err_in_ready", ready_a, 0);
      check("err_n_booted", nboot_a, 1);
      check("err_error", err_a, 1);
    end
    @(negedge clk);
    valid_a = 1'b0;
`endif

    // Random payloads, random source gaps, random trailer quality.
    for (int k = 0; k < 8; k++) begin
      pl.delete();
      for (int i = 0; i < LEN_A; i++) pl.push_back(8'($urandom));
      trailer = good_trailer();
      if ($urandom_range(0, 1) == 1) trailer = trailer ^ 8'($urandom_range(1, 255));
      reset_a();
      foreach (pl[i]) send_a(pl[i], $urandom_range(0, 3));
      finish_load_a($sformatf("rand%0d", k), 3);
    end

    // Full-size load on the 4096-byte instance.
    sum_b = 0;
    bad = 0;
    for (int i = 0; i < LEN_B; i++) begin
      exp_b[i] = 8'($urandom);
      sum_b += int'(exp_b[i]);
      @(negedge clk);
      valid_b = 1'b1; data_b = exp_b[i];
      t = 0;
      #1;
      while (ready_b !== 1'b1 && t < 16) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 16) bad++;
      @(posedge clk);
    end
`ifdef BOOTSTRAP_CHECKSUM_EN
    @(negedge clk);
    data_b = 8'((256 - (sum_b % 256)) % 256);
    t = 0;
    #1;
    while (ready_b !== 1'b1 && t < 16) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 16) bad++;
    @(posedge clk);
`endif
    check("full_hs_timeouts", bad, 0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      data_b = 8'hFF;
    end
    valid_b = 1'b0;
    check("full_n_booted", nboot_b, 0);
    check("full_error", err_b, 0);
    check("full_nwrites", wr_b.size(), LEN_B);
    bad = 0;
    for (int i = 0; i < wr_b.size() && i < LEN_B; i++) begin
      if (wr_b[i].addr != i || wr_b[i].data != int'(exp_b[i])) bad++;
    end
    check("full_write_mismatches", bad, 0);
    if (wr_b.size() > 0) check("full_last_addr", wr_b[wr_b.size()-1].addr, 32'hFFF);
    $display("[TB] load full: %0d bytes, %0d strobes seen, sum %0h", LEN_B, wr_b.size(), sum_b % 256);

    check("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
